// File: rtl/envelope_mult_if.sv
// Multiply request/response bundle between the envelope generator and the
// shared shift-add multiplier.
interface envelope_mult_if #(
   parameter int WAVE_W = 12,
   parameter int ENV_W  = 8
);
   // Handshake: start_i is a one-cycle request honoured only while idle
   // (busy_o low); wave_i/env_i are captured on that edge. ready_o pulses
   // once per accepted request, and product_o/product_full_o stay valid
   // from that pulse until the next one.
   logic                      start_i;
   logic [WAVE_W-1:0]         wave_i;
   logic [ENV_W-1:0]          env_i;
   logic                      busy_o;
   logic                      ready_o;
   logic [WAVE_W-1:0]         product_o;
   logic [WAVE_W+ENV_W-1:0]   product_full_o;
   logic [1:0]                state_o;

   modport master (
      output start_i, wave_i, env_i,
      input  busy_o, ready_o, product_o, product_full_o, state_o
   );

   modport slave (
      input  start_i, wave_i, env_i,
      output busy_o, ready_o, product_o, product_full_o, state_o
   );
endinterface

// File: rtl/envelope_mult.sv
// Signed-by-unsigned shift-add multiplier, one multiplier bit per cycle,
// time-shared by the three voices between waveform path and mixer.
module envelope_mult #(
   parameter int WAVE_W = 12,
   parameter int ENV_W  = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   envelope_mult_if.slave  bus
);
   localparam int FULL_W = WAVE_W + ENV_W;
   localparam int CNT_W  = $clog2(ENV_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ENV_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [FULL_W-1:0]   mcand_q;
   logic [FULL_W-1:0]   acc_q;
   logic [FULL_W-1:0]   acc_sum;
   logic [FULL_W-1:0]   full_q;
   logic [ENV_W-1:0]    mplier_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                last_run;

   // Modular addition is exact here: the true product always fits FULL_W bits.
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      last_run = 1'b0;
      case (state_q)
         IDLE: if (bus.start_i) state_d = RUN;
         RUN: begin
            if (cnt_q == LAST_CNT) begin
               last_run = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         full_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  mcand_q  <= {{ENV_W{bus.wave_i[WAVE_W-1]}}, bus.wave_i};
                  mplier_q <= bus.env_i;
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            RUN: begin
               acc_q    <= acc_sum;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (last_run) full_q <= acc_sum;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o         = (state_q != IDLE);
   assign bus.ready_o        = (state_q == DONE);
   assign bus.product_full_o = full_q;
   assign bus.product_o      = full_q[FULL_W-1:ENV_W];
   assign bus.state_o        = state_q;
endmodule

// File: tb/tb_envelope_mult.sv
// Randomised bench for envelope_mult: integer-arithmetic reference model,
// expected-result queues and per-cycle timing checks.
module tb_envelope_mult;
   localparam int WAVE_W = 12;
   localparam int ENV_W  = 8;
   localparam int FULL_W = WAVE_W + ENV_W;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   logic [FULL_W-1:0] exp_full_q[$];
   logic [WAVE_W-1:0] exp_prod_q[$];
   logic [FULL_W-1:0] prev_full;
   logic [WAVE_W-1:0] prev_prod;

   envelope_mult_if #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) bus ();

   envelope_mult #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Whole-number product, floored by an arithmetic shift of a 64-bit signed value.
   task automatic push_expected(input logic [WAVE_W-1:0] w, input logic [ENV_W-1:0] e);
      longint f;
      f = longint'($signed(w)) * longint'(e);
      exp_full_q.push_back(FULL_W'(f));
      exp_prod_q.push_back(WAVE_W'(f >>> ENV_W));
   endtask

   // Called on a negedge; returns on the negedge of the first idle cycle after DONE.
   task automatic do_op(input logic [WAVE_W-1:0] w, input logic [ENV_W-1:0] e, input int repulse);
      logic [FULL_W-1:0] ef;
      logic [WAVE_W-1:0] ep;
      push_expected(w, e);
      bus.start_i = 1'b1;
      bus.wave_i  = w;
      bus.env_i   = e;
      for (int n = 1; n <= ENV_W + 2; n++) begin
         @(negedge clk);
         check("busy", 32'(bus.busy_o), 32'(n <= ENV_W + 1));
         check("ready", 32'(bus.ready_o), 32'(n == ENV_W + 1));
         if (n <= ENV_W) begin
            check("hold_full", 32'(bus.product_full_o), 32'(prev_full));
         end else if (n == ENV_W + 1) begin
            if (exp_full_q.size() == 0) begin
               check("queue_empty", 32'd1, 32'd0);
            end else begin
               ef = exp_full_q.pop_front();
               ep = exp_prod_q.pop_front();
               check("product_full", 32'(bus.product_full_o), 32'(ef));
               check("product", 32'(bus.product_o), 32'(ep));
               prev_full = ef;
               prev_prod = ep;
            end
         end else begin
            check("held_full", 32'(bus.product_full_o), 32'(prev_full));
            check("held_prod", 32'(bus.product_o), 32'(prev_prod));
         end
         if (n == repulse) begin
            bus.start_i = 1'b1;
            bus.wave_i  = 12'd7;
            bus.env_i   = 8'd3;
         end else begin
            bus.start_i = 1'b0;
            bus.wave_i  = WAVE_W'($urandom);
            bus.env_i   = ENV_W'($urandom);
         end
      end
   endtask

   task automatic reset_mid_run();
      bus.start_i = 1'b1;
      bus.wave_i  = WAVE_W'($urandom_range(1, 2047));
      bus.env_i   = ENV_W'($urandom_range(1, 255));
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
      end
      check("busy_before_rst", 32'(bus.busy_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_ready", 32'(bus.ready_o), 32'd0);
      check("rst_prod", 32'(bus.product_o), 32'd0);
      check("rst_full", 32'(bus.product_full_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_full = '0;
      prev_prod = '0;
      for (int n = 0; n < ENV_W + 4; n++) begin
         @(negedge clk);
         check("no_ready_after_rst", 32'(bus.ready_o), 32'd0);
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      prev_full   = '0;
      prev_prod   = '0;
      rst         = 1'b1;
      bus.start_i = 1'b0;
      bus.wave_i  = '0;
      bus.env_i   = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_busy", 32'(bus.busy_o), 32'd0);
      check("reset_ready", 32'(bus.ready_o), 32'd0);
      check("reset_prod", 32'(bus.product_o), 32'd0);
      check("reset_full", 32'(bus.product_full_o), 32'd0);
      check("reset_state", 32'(bus.state_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op(12'd1000, 8'h80, 0);
      do_op(12'd2047, 8'hFF, 0);
      do_op(12'h800, 8'hFF, 0);
      do_op(12'hFFF, 8'h80, 0);
      do_op(12'hFFB, 8'h00, 0);
      do_op(12'd1234, 8'h55, 3);
      // Three voices back to back: 100*0x10, -300*0x40, 2000*0xC0.
      do_op(12'd100, 8'h10, 0);
      do_op(12'hED4, 8'h40, 0);
      do_op(12'd2000, 8'hC0, 0);

      reset_mid_run();
      do_op(12'd256, 8'hFF, 0);
      check("final_256", 32'(bus.product_o), 32'd255);

      for (int i = 0; i < 25; i++) begin
         do_op(WAVE_W'($urandom), ENV_W'($urandom), int'($urandom_range(0, ENV_W + 1)));
      end

      check("queue_drained", 32'(exp_full_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
